// File: rtl/shift_mac_ctrl.sv
// shift_mac_ctrl: shift-and-add multiply-accumulate controller.
// Computes acc += a*b using an external 34-bit left shifter, one multiplier bit per cycle.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start, acc_clear    operation request and accumulator-clear qualifier
//   a [7:0], b [MBITS]  unsigned multiplicand and multiplier
//   ready               high while idle, i.e. while start can be accepted
//   sh_in, sh_n         operand and shift amount driven to the external shifter
//   sh_out [33:0]       shifter result, sh_in << sh_n
//   acc [33:0]          registered accumulator
//   done                one-cycle completion pulse
//   overflow            sticky carry-out of the accumulator

module shift_mac_ctrl #(
    parameter int MBITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             acc_clear,
    input  logic [7:0]       a,
    input  logic [MBITS-1:0] b,
    output logic             ready,
    output logic [7:0]       sh_in,
    output logic [4:0]       sh_n,
    input  logic [33:0]      sh_out,
    output logic [33:0]      acc,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] CNT_LAST = 5'(MBITS - 1);

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [7:0]       a_q, a_d;
    logic [MBITS-1:0] b_q, b_d;
    logic [33:0]      acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [34:0]      sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        ready   = 1'b0;
        done    = 1'b0;
        sh_in   = '0;
        sh_n    = '0;
        // Bit 34 is the carry out of the accumulator.
        sum     = {1'b0, acc_q} + {1'b0, sh_out};

        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    state_d = RUN;
                    if (acc_clear) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                    end
                end
            end
            RUN: begin
                sh_in = a_q;
                sh_n  = cnt_q;
                // b_q shifts right each step, so bit 0 is multiplier bit cnt_q.
                if (b_q[0]) begin
                    acc_d = sum[33:0];
                    if (sum[34]) begin
                        ovf_d = 1'b1;
                    end
                end
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign acc      = acc_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_shift_mac_ctrl.sv
// tb_shift_mac_ctrl: self-checking bench for shift_mac_ctrl.
// Models the external shifter and an arithmetic MAC reference.

module tb_shift_mac_ctrl;

    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          acc_clear = 1'b0;
    logic [7:0]    a = '0;
    logic [MB-1:0] b = '0;
    logic          ready;
    logic [7:0]    sh_in;
    logic [4:0]    sh_n;
    logic [33:0]   sh_out;
    logic [33:0]   acc;
    logic          done;
    logic          overflow;

    int checks = 0;
    int failures = 0;

    logic [63:0] acc_m = '0;
    logic        ovf_m = 1'b0;

    shift_mac_ctrl #(.MBITS(MB)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .acc_clear (acc_clear),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .sh_in     (sh_in),
        .sh_n      (sh_n),
        .sh_out    (sh_out),
        .acc       (acc),
        .done      (done),
        .overflow  (overflow)
    );

    assign sh_out = 34'(sh_in) << sh_n;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: one whole operation as plain arithmetic.
    task automatic model_op(input logic [7:0] av, input logic [MB-1:0] bv,
                            input bit clr);
        logic [63:0] tot;
        if (clr) begin
            acc_m = '0;
            ovf_m = 1'b0;
        end
        tot = acc_m + 64'(av) * 64'(bv);
        if (tot >= 64'h4_0000_0000) ovf_m = 1'b1;
        acc_m = tot & 64'h3_FFFF_FFFF;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge
    // of the first idle cycle after done.
    task automatic run_op(input logic [7:0] av, input logic [MB-1:0] bv,
                          input bit clr, input bit chk_sh);
        int n;
        chk("ready_pre", 64'(ready), 64'd1);
        start = 1'b1;
        a = av;
        b = bv;
        acc_clear = clr;
        @(posedge clk);
        model_op(av, bv, clr);
        @(negedge clk);
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            if (chk_sh && n <= MB) begin
                chk("sh_in", 64'(sh_in), 64'(av));
                chk("sh_n", 64'(sh_n), 64'(n - 1));
            end
            // Stray requests while busy must be ignored.
            start = 1'($urandom);
            a = 8'($urandom);
            b = MB'($urandom);
            acc_clear = 1'($urandom);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("latency", 64'(n), 64'(MB + 1));
        chk("acc", 64'(acc), acc_m);
        chk("ovf", 64'(overflow), 64'(ovf_m));
        if (chk_sh) begin
            chk("sh_in_done", 64'(sh_in), 64'd0);
            chk("sh_n_done", 64'(sh_n), 64'd0);
            chk("ready_done", 64'(ready), 64'd0);
        end
        @(negedge clk);
        chk("done_width", 64'(done), 64'd0);
        chk("ready_post", 64'(ready), 64'd1);
        chk("acc_hold", 64'(acc), acc_m);
    endtask

    initial begin
        int n;
        logic [7:0] ra;
        logic [MB-1:0] rb;

        repeat (3) @(negedge clk);
        chk("rst_acc", 64'(acc), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_sh_in", 64'(sh_in), 64'd0);
        chk("rst_sh_n", 64'(sh_n), 64'd0);
        reset = 1'b0;

        // First edge after reset accepts.
        run_op(8'hFF, 16'hFFFF, 1'b1, 1'b1);
        chk("ffxffff", 64'(acc), 64'hFEFF01);

        run_op(8'd3, 16'd5, 1'b1, 1'b1);
        chk("mac1", 64'(acc), 64'd15);
        run_op(8'd2, 16'd7, 1'b0, 1'b1);
        chk("mac2", 64'(acc), 64'd29);

        run_op(8'hFF, 16'h0000, 1'b0, 1'b1);
        chk("b_zero", 64'(acc), 64'd29);

        run_op(8'h81, 16'h8001, 1'b1, 1'b1);
        chk("x81", 64'(acc), 64'h408081);

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = MB'($urandom);
            run_op(ra, rb, bit'($urandom_range(0, 3) == 0), 1'b1);
        end

        for (int i = 1; i <= 1029; i++) begin
            run_op(8'hFF, 16'hFFFF, i == 1, 1'b0);
            if (i == 1028) chk("ovf_1028", 64'(overflow), 64'd0);
        end
        chk("ovf_1029", 64'(overflow), 64'd1);
        chk("acc_1029", 64'(acc), 64'hF6FF05);

        // MAC without clear keeps the sticky flag.
        run_op(8'd1, 16'd1, 1'b0, 1'b1);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Reset during RUN cycle 8 aborts with no done.
        start = 1'b1;
        a = 8'hA5;
        b = 16'hFFFF;
        acc_clear = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (n = 1; n < 8; n++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        acc_m = '0;
        ovf_m = 1'b0;
        chk("abort_acc", 64'(acc), 64'd0);
        chk("abort_ovf", 64'(overflow), 64'd0);
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_sh_in", 64'(sh_in), 64'd0);
        n = 0;
        for (int i = 0; i < 25; i++) begin
            if (done === 1'b1) n++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(n), 64'd0);

        run_op(8'd9, 16'd11, 1'b0, 1'b1);
        chk("post_abort", 64'(acc), 64'd99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_mac_ctrl.md
SHIFT_MAC_CTRL -- requirements
Module: shift_mac_ctrl

Interface
REQ-001 Parameter: MBITS, default 16, multiplier operand width; legal range 1..26.
REQ-002 Port: clk  input  1  rising-edge clock; sole clock domain.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  operation request, sampled only while ready=1.
REQ-005 Port: acc_clear  input  1  sampled with accepted start; 1 = zero acc and overflow before the operation.
REQ-006 Port: a  input  8  multiplicand, unsigned.
REQ-007 Port: b  input  MBITS  multiplier, unsigned.
REQ-008 Port: ready  output  1  high in IDLE only.
REQ-009 Port: sh_in  output  8  data to the external 34-bit shifter.
REQ-010 Port: sh_n  output  5  shift amount to the external shifter.
REQ-011 Port: sh_out  input  34  shifter result; combinationally equals sh_in << sh_n, zero-extended.
REQ-012 Port: acc  output  34  accumulator, registered.
REQ-013 Port: done  output  1  single-cycle completion pulse.
REQ-014 Port: overflow  output  1  sticky accumulator carry-out flag.

Function
REQ-015 FSM states: IDLE, RUN, DONE.
REQ-016 IDLE: ready=1; start=1 accepts the operation, latches a and b, and clears the bit counter. If acc_clear=1, the same edge sets acc=0 and overflow=0. Next state RUN.
REQ-017 start while in RUN or DONE is ignored; no queuing.
REQ-018 RUN: bit counter i steps 0..MBITS-1, one step per cycle; sh_in=a_latched, sh_n=i.
REQ-019 RUN, when b_latched[i]=1: acc <= (acc + sh_out) mod 2^34; a carry out of bit 33 sets overflow. When b_latched[i]=0: acc holds.
REQ-020 RUN has a fixed length of MBITS cycles regardless of operand values; no early termination, including for a=0 or b=0.
REQ-021 When i=MBITS-1 completes, the next state is DONE. DONE asserts done=1 for exactly one cycle, then goes to IDLE.
REQ-022 Latency: start accepted at edge T → done high during cycle T+MBITS+1; ready high again on the cycle after done.
REQ-023 Outside RUN: sh_in=0 and sh_n=0.
REQ-024 acc and overflow hold their values in IDLE and DONE. acc is readable as the final result while done=1 and afterwards.
REQ-025 overflow clears only on reset or on an accepted start with acc_clear=1. The same edge may clear and later re-set it within that operation.
REQ-026 With acc_clear=0, an accepted start adds a*b to the existing acc (MAC mode).

Reset
REQ-027 On reset=1 at a clock edge: state=IDLE, acc=0, overflow=0, done=0, ready=1 (next cycle), sh_in=0, sh_n=0, counter=0.
REQ-028 Reset dominates start and any in-progress operation. A reset during RUN aborts without asserting done.
REQ-029 The first cycle after reset deasserts may accept start.

Verification
REQ-030 Scenario: after reset, start with a=0xFF, b=0xFFFF, acc_clear=1 → done exactly 17 cycles after the accept edge, acc=0x0000FEFF01, overflow=0.
REQ-031 Scenario: a=3, b=5, acc_clear=1, then a=2, b=7, acc_clear=0 → acc=15 after the first done, acc=29 after the second.
REQ-032 Scenario: 1029 back-to-back MAC operations with a=0xFF, b=0xFFFF (first with acc_clear=1) → overflow=0 after op 1028, overflow=1 after op 1029, acc=0xF6FF05.
REQ-033 Scenario: a=0x81, b=0x8001 → sh_in=0x81 for all 16 RUN cycles, sh_n=0,1,...,15 in order, acc=0x81*0x8001=0x408081; start pulses during RUN have no effect.
REQ-034 Scenario: a=0xFF, b=0 → acc unchanged, done still at accept+17.
REQ-035 Scenario: reset asserted in RUN cycle 8 → acc=0, overflow=0, ready=1 the following cycle, no done pulse.
